// File: rtl/sdcard_cmd.sv
// SD-card SPI-mode command sequencer: PRE, 5-byte command, CRC7, R1 hunt.
// Define SDCARD_CMD_BUSY_WAIT_EN to add R1b busy polling after the R1 byte.
module sdcard_cmd #(
    parameter int          RESP_TRIES   = 8,
    parameter logic [15:0] BUSY_TIMEOUT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        busy_wait,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic [7:0]  resp_r1,
    output logic        resp_timeout,
    output logic [7:0]  spi_data_out,
    output logic [4:0]  spi_bits,
    output logic        spi_start,
    input  logic [7:0]  spi_data_in,
    input  logic        spi_finished,
    input  logic        crc_out_bit,
    input  logic        crc_strobe
);

    typedef enum logic [2:0] {
        IDLE, PRE, CMD, CRC, RESP, BUSYW, DONE
    } state_e;

    localparam int TW = $clog2(RESP_TRIES + 1);

    state_e        state_q, state_d;
    logic [5:0]    idx_q, idx_d;
    logic [31:0]   arg_q, arg_d;
    logic [6:0]    crc_q, crc_d;
    logic [2:0]    byte_q, byte_d;
    logic [TW-1:0] try_q, try_d;
    logic          start_q, start_d;
    logic [7:0]    dout_q, dout_d;
    logic [4:0]    bits_q, bits_d;
    logic [7:0]    r1_q, r1_d;
    logic          to_q, to_d;
    logic          fb;
    logic [7:0]    nbyte;
`ifdef SDCARD_CMD_BUSY_WAIT_EN
    logic          bw_q, bw_d;
    logic [15:0]   bcnt_q, bcnt_d;
`else
    logic          unused_cfg;
    assign unused_cfg = busy_wait | (^BUSY_TIMEOUT);
`endif

    assign cmd_busy     = (state_q != IDLE);
    assign cmd_done     = (state_q == DONE);
    assign resp_r1      = r1_q;
    assign resp_timeout = to_q;
    assign spi_data_out = dout_q;
    assign spi_bits     = bits_q;
    assign spi_start    = start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            arg_q   <= '0;
            crc_q   <= '0;
            byte_q  <= '0;
            try_q   <= '0;
            start_q <= 1'b0;
            dout_q  <= 8'hFF;
            bits_q  <= '0;
            r1_q    <= 8'hFF;
            to_q    <= 1'b0;
`ifdef SDCARD_CMD_BUSY_WAIT_EN
            bw_q    <= 1'b0;
            bcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            arg_q   <= arg_d;
            crc_q   <= crc_d;
            byte_q  <= byte_d;
            try_q   <= try_d;
            start_q <= start_d;
            dout_q  <= dout_d;
            bits_q  <= bits_d;
            r1_q    <= r1_d;
            to_q    <= to_d;
`ifdef SDCARD_CMD_BUSY_WAIT_EN
            bw_q    <= bw_d;
            bcnt_q  <= bcnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        arg_d   = arg_q;
        crc_d   = crc_q;
        byte_d  = byte_q;
        try_d   = try_q;
        start_d = 1'b0;
        dout_d  = dout_q;
        bits_d  = bits_q;
        r1_d    = r1_q;
        to_d    = to_q;
`ifdef SDCARD_CMD_BUSY_WAIT_EN
        bw_d    = bw_q;
        bcnt_d  = bcnt_q;
`endif
        fb = crc_q[6] ^ crc_out_bit;
        // byte following the one at byte_q (0 = index byte)
        unique case (byte_q)
            3'd0:    nbyte = arg_q[31:24];
            3'd1:    nbyte = arg_q[23:16];
            3'd2:    nbyte = arg_q[15:8];
            default: nbyte = arg_q[7:0];
        endcase

        unique case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    idx_d   = cmd_index;
                    arg_d   = cmd_arg;
                    crc_d   = '0;
                    byte_d  = '0;
                    try_d   = '0;
                    to_d    = 1'b0;
`ifdef SDCARD_CMD_BUSY_WAIT_EN
                    bw_d    = busy_wait;
`endif
                    state_d = PRE;
                    start_d = 1'b1;
                    dout_d  = 8'hFF;
                    bits_d  = 5'd7;
                end
            end
            PRE: begin
                if (spi_finished) begin
                    state_d = CMD;
                    byte_d  = '0;
                    start_d = 1'b1;
                    dout_d  = {2'b01, idx_q};
                end
            end
            CMD: begin
                if (crc_strobe) begin
                    crc_d = {crc_q[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
                end
                if (spi_finished) begin
                    start_d = 1'b1;
                    if (byte_q == 3'd4) begin
                        state_d = CRC;
                        dout_d  = {crc_d, 1'b1};
                    end else begin
                        byte_d = byte_q + 3'd1;
                        dout_d = nbyte;
                    end
                end
            end
            CRC: begin
                if (spi_finished) begin
                    state_d = RESP;
                    try_d   = '0;
                    start_d = 1'b1;
                    dout_d  = 8'hFF;
                    bits_d  = 5'd31;
                end
            end
            RESP: begin
                if (spi_finished) begin
                    if (!spi_data_in[7]) begin
                        r1_d = spi_data_in;
`ifdef SDCARD_CMD_BUSY_WAIT_EN
                        if (bw_q) begin
                            state_d = BUSYW;
                            bcnt_d  = '0;
                            start_d = 1'b1;
                            dout_d  = 8'hFF;
                            bits_d  = 5'd7;
                        end else begin
                            state_d = DONE;
                        end
`else
                        state_d = DONE;
`endif
                    end else if (try_q + TW'(1) == TW'(RESP_TRIES)) begin
                        r1_d    = 8'hFF;
                        to_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        try_d   = try_q + TW'(1);
                        start_d = 1'b1;
                    end
                end
            end
`ifdef SDCARD_CMD_BUSY_WAIT_EN
            BUSYW: begin
                if (spi_finished) begin
                    bcnt_d = bcnt_q + 16'd1;
                    if (spi_data_in == 8'hFF) begin
                        state_d = DONE;
                    end else if (bcnt_q + 16'd1 == BUSY_TIMEOUT) begin
                        to_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        start_d = 1'b1;
                    end
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sdcard_cmd.sv
// Directed bench for sdcard_cmd with an SPI shifter and SD card model.
// Covers CMD0/CMD8 CRC, R1 hunt timeout, busy wait, async reset, re-pulse.
module tb_sdcard_cmd;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        busy_wait;
    logic        cmd_busy;
    logic        cmd_done;
    logic [7:0]  resp_r1;
    logic        resp_timeout;
    logic [7:0]  spi_data_out;
    logic [4:0]  spi_bits;
    logic        spi_start;
    logic [7:0]  spi_data_in;
    logic        spi_finished;
    logic        crc_out_bit;
    logic        crc_strobe;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int start_err = 0;
    bit in_busy = 0;
    bit repulsed = 0;
    logic [12:0] xlog[$];
    logic [7:0]  rq[$];
    logic [7:0]  bq[$];

    sdcard_cmd dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_start    (cmd_start),
        .cmd_index    (cmd_index),
        .cmd_arg      (cmd_arg),
        .busy_wait    (busy_wait),
        .cmd_busy     (cmd_busy),
        .cmd_done     (cmd_done),
        .resp_r1      (resp_r1),
        .resp_timeout (resp_timeout),
        .spi_data_out (spi_data_out),
        .spi_bits     (spi_bits),
        .spi_start    (spi_start),
        .spi_data_in  (spi_data_in),
        .spi_finished (spi_finished),
        .crc_out_bit  (crc_out_bit),
        .crc_strobe   (crc_strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] getlog(input int i);
        return (i < xlog.size()) ? xlog[i] : 13'h1FFF;
    endfunction

    function automatic int n_resp();
        int n = 0;
        foreach (xlog[i]) if (xlog[i][12:8] == 5'd31) n++;
        return n;
    endfunction

    // SPI shifter plus card: one strobe per bit, then a finished pulse
    initial begin
        logic [4:0] b;
        logic [7:0] d;
        logic [7:0] r;
        spi_finished = 1'b0;
        crc_strobe   = 1'b0;
        crc_out_bit  = 1'b0;
        spi_data_in  = 8'hFF;
        forever begin
            @(negedge clk);
            spi_finished = 1'b0;
            if (spi_start && !rst) begin
                b = spi_bits;
                d = spi_data_out;
                xlog.push_back({b, d});
                for (int i = 0; i <= int'(b); i++) begin
                    crc_out_bit = (i < 8) ? d[7-i] : 1'b1;
                    crc_strobe  = 1'b1;
                    @(negedge clk);
                end
                crc_strobe = 1'b0;
                if (b == 5'd31) begin
                    r = (rq.size() > 0) ? rq.pop_front() : 8'hFF;
                    if (!r[7]) in_busy = 1'b1;
                end else begin
                    r = (in_busy && bq.size() > 0) ? bq.pop_front() : 8'hFF;
                end
                spi_data_in  = r;
                spi_finished = 1'b1;
            end
        end
    end

    initial begin
        bit prev = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_done) done_cnt++;
            if (prev && spi_start) start_err++;
            prev = spi_start;
        end
    end

    task automatic launch(input logic [5:0] idx, input logic [31:0] arg,
                          input logic bw);
        @(negedge clk);
        xlog.delete();
        in_busy   = 1'b0;
        cmd_index = idx;
        cmd_arg   = arg;
        busy_wait = bw;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input logic [5:0] idx,
                           input logic [31:0] arg, input logic bw,
                           input bit rep);
        int d0;
        bit ok = 1'b0;
        d0 = done_cnt;
        repulsed = 1'b0;
        launch(idx, arg, bw);
        for (int i = 0; i < 3000; i++) begin
            logic [12:0] last;
            @(negedge clk);
            last = (xlog.size() > 0) ? xlog[xlog.size()-1] : 13'h0;
            if (rep && !repulsed && last[12:8] == 5'd31) begin
                cmd_index = 6'd0;
                cmd_arg   = 32'h0;
                cmd_start = 1'b1;
                repulsed  = 1'b1;
            end else begin
                cmd_start = 1'b0;
            end
            if (cmd_done) begin
                ok = 1'b1;
                break;
            end
        end
        cmd_start = 1'b0;
        if (!ok) chk({tag, "_done_wait"}, 32'd0, 32'd1);
        @(negedge clk);
        chk({tag, "_busy_after"}, 32'(cmd_busy), 32'd0);
        chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        logic [7:0] exp0 [7];
        int d0;
        bit seen;
        exp0 = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
        rst = 1'b1;
        cmd_start = 1'b0;
        cmd_index = '0;
        cmd_arg   = '0;
        busy_wait = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(cmd_busy), 32'd0);
        chk("rst_done", 32'(cmd_done), 32'd0);
        chk("rst_r1", 32'(resp_r1), 32'hFF);
        chk("rst_to", 32'(resp_timeout), 32'd0);
        chk("rst_dout", 32'(spi_data_out), 32'hFF);
        chk("rst_bits", 32'(spi_bits), 32'd0);
        chk("rst_start", 32'(spi_start), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        rq = '{8'h01};
        run_cmd("cmd0", 6'd0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++)
            chk($sformatf("cmd0_b%0d", i), 32'(getlog(i)), 32'({5'd7, exp0[i]}));
        chk("cmd0_resp", 32'(getlog(7)), 32'({5'd31, 8'hFF}));
        chk("cmd0_nxfer", xlog.size(), 32'd8);
        chk("cmd0_r1", 32'(resp_r1), 32'h01);
        chk("cmd0_to", 32'(resp_timeout), 32'd0);

        rq = '{8'h01};
        run_cmd("cmd8", 6'd8, 32'h000001AA, 1'b0, 1'b0);
        chk("cmd8_b1", 32'(getlog(1)), 32'({5'd7, 8'h48}));
        chk("cmd8_b4", 32'(getlog(4)), 32'({5'd7, 8'h01}));
        chk("cmd8_b5", 32'(getlog(5)), 32'({5'd7, 8'hAA}));
        chk("cmd8_crc", 32'(getlog(6)), 32'({5'd7, 8'h87}));
        chk("cmd8_r1", 32'(resp_r1), 32'h01);

        rq.delete();
        run_cmd("tmo", 6'd55, 32'h0, 1'b0, 1'b0);
        chk("tmo_nresp", n_resp(), 32'd8);
        chk("tmo_nxfer", xlog.size(), 32'd15);
        chk("tmo_r1", 32'(resp_r1), 32'hFF);
        chk("tmo_to", 32'(resp_timeout), 32'd1);

        rq = '{8'hFF, 8'hFF, 8'h01};
        run_cmd("rep", 6'd8, 32'h000001AA, 1'b0, 1'b1);
        chk("rep_pulsed", 32'(repulsed), 32'd1);
        chk("rep_nxfer", xlog.size(), 32'd10);
        chk("rep_crc", 32'(getlog(6)), 32'({5'd7, 8'h87}));
        chk("rep_r1", 32'(resp_r1), 32'h01);
        chk("rep_to", 32'(resp_timeout), 32'd0);

        rq = '{8'h00};
        bq = '{8'h00, 8'h00, 8'h00, 8'hFF};
        run_cmd("bsy", 6'd12, 32'h0, 1'b1, 1'b0);
`ifdef SDCARD_CMD_BUSY_WAIT_EN
        chk("bsy_nbusy", xlog.size() - 8, 32'd4);
        chk("bsy_bits", 32'(getlog(8)), 32'({5'd7, 8'hFF}));
`else
        chk("bsy_nxfer", xlog.size(), 32'd8);
`endif
        chk("bsy_r1", 32'(resp_r1), 32'h00);
        chk("bsy_to", 32'(resp_timeout), 32'd0);
        bq.delete();

        rq = '{8'h01};
        launch(6'd17, 32'h12345678, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = (xlog.size() >= 3);
        end
        chk("rst_mid_reached", 32'(seen), 32'd1);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        chk("rstm_busy", 32'(cmd_busy), 32'd0);
        chk("rstm_r1", 32'(resp_r1), 32'hFF);
        chk("rstm_dout", 32'(spi_data_out), 32'hFF);
        chk("rstm_bits", 32'(spi_bits), 32'd0);
        chk("rstm_start", 32'(spi_start), 32'd0);
        repeat (60) @(negedge clk);
        chk("rstm_no_done", done_cnt - d0, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rq = '{8'h01};
        run_cmd("post", 6'd0, 32'h0, 1'b0, 1'b0);
        chk("post_b1", 32'(getlog(1)), 32'({5'd7, 8'h40}));
        chk("post_crc", 32'(getlog(6)), 32'({5'd7, 8'h95}));
        chk("post_r1", 32'(resp_r1), 32'h01);

        chk("start_one_cycle", start_err, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdcard_cmd.md
SDCARD_CMD -- requirements
Module: sdcard_cmd

Interface
REQ-001 Parameter RESP_TRIES, default 8: maximum number of response-hunt transfers before a response timeout.
REQ-002 Parameter BUSY_TIMEOUT, default 16'hFFFF: maximum number of busy-poll bytes (only with SDCARD_CMD_BUSY_WAIT_EN).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 cmd_start  in  1  one-cycle pulse; launch command.
REQ-007 cmd_index  in  6  command number, sampled at cmd_start.
REQ-008 cmd_arg  in  32  argument, sampled at cmd_start.
REQ-009 busy_wait  in  1  R1b command, sampled at cmd_start.
REQ-010 cmd_busy  out  1  high from the cycle after cmd_start to the cycle of cmd_done.
REQ-011 cmd_done  out  1  one-cycle completion pulse.
REQ-012 resp_r1  out  8  captured R1 byte; valid at cmd_done.
REQ-013 resp_timeout  out  1  response or busy timeout; valid at cmd_done.
REQ-014 spi_data_out  out  8  byte to the SPI shifter.
REQ-015 spi_bits  out  5  bit count to the SPI shifter (count minus one).
REQ-016 spi_start  out  1  one-cycle shifter start pulse.
REQ-017 spi_data_in  in  8  received byte from the shifter.
REQ-018 spi_finished  in  1  shifter completion pulse.
REQ-019 crc_out_bit  in  1  bit currently being shifted out.
REQ-020 crc_strobe  in  1  qualifies crc_out_bit, one pulse per transmitted bit.

Function
REQ-021 The FSM SHALL use the states IDLE, PRE, CMD, CRC, RESP, BUSYW and DONE.
REQ-022 In IDLE, cmd_start SHALL latch the inputs, clear CRC7 to 0 and enter PRE; cmd_start outside IDLE SHALL be ignored.
REQ-023 On entry to each transfer state the block SHALL pulse spi_start for exactly one cycle, hold spi_data_out and spi_bits constant until spi_finished, and advance only on spi_finished.
REQ-024 PRE SHALL send 8'hFF with spi_bits=7.
REQ-025 CMD SHALL send 5 bytes, spi_bits=7, MSB first: {2'b01,cmd_index}, then cmd_arg[31:24], [23:16], [15:8], [7:0], using a 3-bit byte counter.
REQ-026 CRC7 SHALL update only in CMD on crc_strobe: fb=crc[6]^crc_out_bit; crc={crc[5:0],1'b0}^(fb?7'h09:7'h00).
REQ-027 CRC SHALL send {crc7,1'b1} with spi_bits=7.
REQ-028 RESP SHALL send 8'hFF with spi_bits=31; on spi_finished, spi_data_in[7]==0 SHALL capture resp_r1; otherwise the try counter SHALL increment, and after RESP_TRIES failed hunts resp_r1=8'hFF and resp_timeout=1, then DONE.
REQ-029 On a valid R1, the FSM SHALL go to BUSYW if busy_wait is set and the macro is defined, else to DONE.
REQ-030 DONE SHALL pulse cmd_done for one cycle and return to IDLE; cmd_busy SHALL be low in the following cycle.
REQ-031 resp_r1 and resp_timeout SHALL hold their values until the next cmd_start, which clears resp_timeout.

Reset
REQ-032 rst SHALL asynchronously force: state IDLE, spi_start=0, cmd_busy=0, cmd_done=0, resp_r1=8'hFF, resp_timeout=0, spi_data_out=8'hFF, spi_bits=0, CRC7 and all counters to 0.
REQ-033 Reset mid-command SHALL abandon the command without a cmd_done pulse.

Configuration
REQ-034 With SDCARD_CMD_BUSY_WAIT_EN defined, BUSYW SHALL send 8'hFF with spi_bits=7 repeatedly until spi_data_in==8'hFF (then DONE), or until BUSY_TIMEOUT bytes have been sent (then resp_timeout=1, resp_r1 kept, DONE).
REQ-035 Without SDCARD_CMD_BUSY_WAIT_EN, busy_wait SHALL be ignored and BUSYW logic and its 16-bit counter SHALL be absent.

Verification
REQ-036 CMD0, arg 0, card model answers 0x01 -> SPI bytes FF,40,00,00,00,00,95; resp_r1=01, resp_timeout=0, one cmd_done pulse.
REQ-037 CMD8, arg 32'h000001AA -> CRC byte 0x87; R1 0x01 captured.
REQ-038 MISO held high -> exactly 8 RESP transfers with spi_bits=31; resp_r1=FF, resp_timeout=1.
REQ-039 Macro on, busy_wait=1, card returns 00 for 3 bytes then FF -> 4 BUSYW bytes; resp_timeout=0.
REQ-040 rst asserted during CMD byte 2 -> outputs reach reset values immediately with no clock edge; no cmd_done; next cmd_start completes normally.
REQ-041 cmd_start re-pulsed during RESP -> ignored; latched index and argument unchanged.
